// File: rtl/imem_loader.sv
// imem_loader: streams a byte-serial program image into instruction memory.
// Image format: 16-bit little-endian word count, then count*4 payload bytes
// packed little-endian into 32-bit words, then one 8-bit additive checksum
// of the payload bytes. The core is released only after a good checksum.
module imem_loader #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int          MAX_WORDS = 256
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        byte_valid,
   input  logic [7:0]  byte_data,
   output logic        byte_ready,
   output logic        imem_we,
   output logic [31:0] imem_addr,
   output logic [31:0] imem_wdata,
   output logic        core_run,
   output logic        busy,
   output logic        done,
   output logic        error
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_HDR0 = 3'd1;
   localparam logic [2:0] S_HDR1 = 3'd2;
   localparam logic [2:0] S_DATA = 3'd3;
   localparam logic [2:0] S_CSUM = 3'd4;
   localparam logic [2:0] S_DONE = 3'd5;
   localparam logic [2:0] S_ERR  = 3'd6;

   localparam logic [16:0] MAX_LIMIT = 17'(MAX_WORDS);

   logic [2:0]  state;
   logic [2:0]  state_next;
   logic [15:0] count;
   logic [15:0] index;
   logic [1:0]  byte_cnt;
   logic [7:0]  csum;
   logic [23:0] word_buf;

   logic        accept;
   logic        start_ok;
   logic        last_byte;
   logic        last_word;
   logic [15:0] hdr_count;

   assign accept    = byte_valid & byte_ready;
   assign start_ok  = start & ((state == S_IDLE) | (state == S_DONE) | (state == S_ERR));
   assign last_byte = (byte_cnt == 2'd3);
   assign last_word = (index == (count - 16'd1));
   assign hdr_count = {byte_data, count[7:0]};

   // Byte acceptance window: only the four states that consume image bytes
   always_comb begin
      byte_ready = 1'b0;
      case (state)
         S_HDR0, S_HDR1, S_DATA, S_CSUM: byte_ready = 1'b1;
         default:                        byte_ready = 1'b0;
      endcase
   end

   // Next-state decode for the load sequence
   always_comb begin
      state_next = state;
      case (state)
         S_IDLE, S_DONE, S_ERR: begin
            if (start) state_next = S_HDR0;
         end
         S_HDR0: begin
            if (accept) state_next = S_HDR1;
         end
         S_HDR1: begin
            if (accept) begin
               if (hdr_count == 16'd0)                 state_next = S_CSUM;
               else if ({1'b0, hdr_count} > MAX_LIMIT) state_next = S_ERR;
               else                                    state_next = S_DATA;
            end
         end
         S_DATA: begin
            if (accept && last_byte && last_word) state_next = S_CSUM;
         end
         S_CSUM: begin
            if (accept) state_next = (byte_data == csum) ? S_DONE : S_ERR;
         end
         default: state_next = S_IDLE;
      endcase
   end

   // State register plus status flags registered from the next state so they line up with it
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= S_IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         error    <= 1'b0;
         core_run <= 1'b0;
      end else begin
         state    <= state_next;
         busy     <= (state_next == S_HDR0) | (state_next == S_HDR1) |
                     (state_next == S_DATA) | (state_next == S_CSUM);
         done     <= (state_next == S_DONE);
         error    <= (state_next == S_ERR);
         core_run <= (state_next == S_DONE);
      end
   end

   // Header capture, word assembly, checksum accumulation and the write strobe
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count      <= 16'd0;
         index      <= 16'd0;
         byte_cnt   <= 2'd0;
         csum       <= 8'd0;
         word_buf   <= 24'd0;
         imem_we    <= 1'b0;
         imem_addr  <= BASE_ADDR;
         imem_wdata <= 32'd0;
      end else begin
         imem_we <= 1'b0;
         if (start_ok) begin
            count    <= 16'd0;
            index    <= 16'd0;
            byte_cnt <= 2'd0;
            csum     <= 8'd0;
            word_buf <= 24'd0;
         end else if (accept) begin
            case (state)
               S_HDR0: count[7:0]  <= byte_data;
               S_HDR1: count[15:8] <= byte_data;
               S_DATA: begin
                  csum     <= csum + byte_data;
                  byte_cnt <= byte_cnt + 2'd1;
                  case (byte_cnt)
                     2'd0: word_buf[7:0]   <= byte_data;
                     2'd1: word_buf[15:8]  <= byte_data;
                     2'd2: word_buf[23:16] <= byte_data;
                     default: begin
                        imem_we    <= 1'b1;
                        imem_wdata <= {byte_data, word_buf};
                        imem_addr  <= BASE_ADDR + {14'd0, index, 2'b00};
                        index      <= index + 16'd1;
                     end
                  endcase
               end
               default: ;
            endcase
         end
      end
   end

endmodule
